// File: rtl/led_mode_ctrl_if.sv
// Key/LED bundle for the board mode controller.
// master drives the raw keys, slave is the controller.
interface led_mode_ctrl_if;
  logic [3:0] key;
  logic [3:0] led;
  logic [2:0] mode;
  logic [3:0] key_evt;
  logic       step_tick;

  modport master (
    output key,
    input  led, mode, key_evt, step_tick
  );

  modport slave (
    input  key,
    output led, mode, key_evt, step_tick
  );
endinterface

// File: rtl/led_mode_ctrl.sv
// Debounced 4-key mode selector driving a stepped 4-LED pattern.
// Keys toggle latched modes; patterns advance on a shared step timer.
module led_mode_ctrl #(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int STEP_CNT     = 10_000_000
) (
  input logic           sys_clk,
  input logic           rst_n,
  led_mode_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam int SW = $clog2(STEP_CNT);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CNT - 1);
  localparam logic [SW-1:0] ST_MAX = SW'(STEP_CNT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT_L = 3'd1,
    SHIFT_R = 3'd2,
    BLINK   = 3'd3,
    ALL_ON  = 3'd4
  } mode_e;

  logic [3:0]    key_s1;
  logic [3:0]    key_s2;
  logic [3:0]    stable;
  logic [3:0]    stable_d;
  logic [3:0]    key_evt_q;
  logic [DW-1:0] db_cnt [4];

  mode_e         mode_q;
  mode_e         tgt;
  mode_e         mode_nxt;
  logic          mode_chg;
  logic [SW-1:0] step_cnt;
  logic [1:0]    phase;
  logic          tick;
  logic [3:0]    led_q;
  logic [3:0]    led_nxt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1    <= 4'hF;
      key_s2    <= 4'hF;
      stable    <= 4'hF;
      stable_d  <= 4'hF;
      key_evt_q <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      key_s1    <= bus.key;
      key_s2    <= key_s1;
      stable_d  <= stable;
      key_evt_q <= stable_d & ~stable;
      for (int i = 0; i < 4; i++) begin
        if (key_s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= key_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // lowest key index wins when several presses land together
  always_comb begin
    tgt = IDLE;
    priority case (1'b1)
      key_evt_q[0]: tgt = SHIFT_L;
      key_evt_q[1]: tgt = SHIFT_R;
      key_evt_q[2]: tgt = BLINK;
      key_evt_q[3]: tgt = ALL_ON;
      default:      tgt = IDLE;
    endcase
  end

  always_comb begin
    mode_nxt = mode_q;
    if (|key_evt_q) begin
      mode_nxt = (mode_q == tgt) ? IDLE : tgt;
    end
    mode_chg = (mode_nxt != mode_q);
  end

  assign tick = (step_cnt == ST_MAX);

  always_comb begin
    led_nxt = 4'h0;
    case (mode_q)
      SHIFT_L: led_nxt = 4'b0001 << phase;
      SHIFT_R: led_nxt = 4'b1000 >> phase;
      BLINK:   led_nxt = {4{~phase[0]}};
      ALL_ON:  led_nxt = 4'hF;
      default: led_nxt = 4'h0;
    endcase
  end

  // a mode switch restarts the pattern at phase 0 with a full step
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= IDLE;
      step_cnt <= '0;
      phase    <= 2'd0;
      led_q    <= 4'h0;
    end else begin
      mode_q <= mode_nxt;
      led_q  <= led_nxt;
      if (mode_chg) begin
        step_cnt <= '0;
        phase    <= 2'd0;
      end else if (tick) begin
        step_cnt <= '0;
        phase    <= phase + 2'd1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  assign bus.led       = led_q;
  assign bus.mode      = mode_q;
  assign bus.key_evt   = key_evt_q;
  assign bus.step_tick = tick;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with a per-cycle reference model.
// Model follows the behavioural rules; literal checks pin key moments.
module tb_led_mode_ctrl;

  localparam int D = 4;
  localparam int S = 5;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  led_mode_ctrl_if bus();

  led_mode_ctrl #(
    .DEBOUNCE_CNT(D),
    .STEP_CNT(S)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int evt_cnt [4] = '{0, 0, 0, 0};

  function automatic void cmp(string nm, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference model state
  logic [3:0] m_p0     = 4'hF;
  logic [3:0] m_p1     = 4'hF;
  logic [3:0] m_stable = 4'hF;
  logic [3:0] m_fell   = 4'h0;
  logic [3:0] m_evt    = 4'h0;
  logic [3:0] m_led    = 4'h0;
  int m_run [4] = '{0, 0, 0, 0};
  int m_mode  = 0;
  int m_phase = 0;
  int m_cnt   = 0;

  logic [3:0] shl_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] shr_tab [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  function automatic logic [3:0] m_pattern(int md, int ph);
    case (md)
      1: return shl_tab[ph];
      2: return shr_tab[ph];
      3: return (ph % 2 == 0) ? 4'hF : 4'h0;
      4: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_p0 = 4'hF; m_p1 = 4'hF; m_stable = 4'hF;
    m_fell = 4'h0; m_evt = 4'h0; m_led = 4'h0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_mode = 0; m_phase = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [3:0] led_n;
    logic [3:0] evt_n;
    logic [3:0] fell_n;
    int mode_n;
    int tgt;
    led_n  = m_pattern(m_mode, m_phase);
    mode_n = m_mode;
    tgt    = 0;
    for (int i = 3; i >= 0; i--) if (m_evt[i]) tgt = i + 1;
    if (m_evt != 4'h0) mode_n = (m_mode == tgt) ? 0 : tgt;
    if (mode_n != m_mode) begin
      m_cnt = 0;
      m_phase = 0;
    end else if (m_cnt == S - 1) begin
      m_cnt = 0;
      m_phase = (m_phase + 1) % 4;
    end else begin
      m_cnt++;
    end
    evt_n  = m_fell;
    fell_n = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (m_p1[i] !== m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_stable[i] = m_p1[i];
          m_run[i] = 0;
          fell_n[i] = ~m_p1[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_p1 = m_p0;
    m_p0 = bus.key;
    m_mode = mode_n;
    m_led = led_n;
    m_evt = evt_n;
    m_fell = fell_n;
  endtask

  initial begin
    forever begin
      @(posedge sys_clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      cmp("cyc_led", bus.led, m_led);
      cmp("cyc_mode", {1'b0, bus.mode}, 4'(m_mode));
      cmp("cyc_evt", bus.key_evt, m_evt);
      cmp("cyc_tick", {3'b0, bus.step_tick}, {3'b0, m_cnt == S - 1});
      for (int i = 0; i < 4; i++) if (bus.key_evt[i] === 1'b1) evt_cnt[i]++;
    end
  end

  task automatic lit(string nm, logic [3:0] dv, logic [3:0] mv, logic [3:0] exp);
    cmp(nm, dv, exp);
    cmp({nm, "_model"}, mv, exp);
  endtask

  task automatic wn(int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    bus.key = 4'hF;
    wn(3);
    rst_n = 1'b1;
    lit("rst_led", bus.led, m_led, 4'h0);
    lit("rst_mode", {1'b0, bus.mode}, 4'(m_mode), 4'h0);
    lit("rst_evt", bus.key_evt, m_evt, 4'h0);
    cmp("rst_tick", {3'b0, bus.step_tick}, 4'h0);

    // hold key0: one event, SHIFT_L sequence
    bus.key = 4'b1110;
    wn(7);
    lit("k0_evt", bus.key_evt, m_evt, 4'b0001);
    wn(1);
    lit("k0_mode", {1'b0, bus.mode}, 4'(m_mode), 4'd1);
    wn(1);
    lit("shl_p0", bus.led, m_led, 4'b0001);
    wn(5);
    lit("shl_p1", bus.led, m_led, 4'b0010);
    wn(5);
    lit("shl_p2", bus.led, m_led, 4'b0100);
    wn(1);
    bus.key = 4'hF;
    wn(4);
    lit("shl_p3", bus.led, m_led, 4'b1000);
    wn(5);
    lit("shl_wrap", bus.led, m_led, 4'b0001);
    wn(6);
    cmp("k0_once", 4'(evt_cnt[0]), 4'd1);

    // second key0 press toggles back to IDLE
    bus.key = 4'b1110;
    wn(8);
    lit("k0_idle", {1'b0, bus.mode}, 4'(m_mode), 4'd0);
    wn(1);
    lit("idle_led", bus.led, m_led, 4'h0);
    wn(3);
    bus.key = 4'hF;
    wn(10);
    lit("idle_hold", bus.led, m_led, 4'h0);
    cmp("k0_twice", 4'(evt_cnt[0]), 4'd2);

    // short glitch on key1 is ignored
    bus.key = 4'b1101;
    wn(3);
    bus.key = 4'hF;
    wn(12);
    cmp("k1_glitch", 4'(evt_cnt[1]), 4'd0);
    lit("glitch_mode", {1'b0, bus.mode}, 4'(m_mode), 4'd0);

    // key3+key2 together: BLINK wins
    bus.key = 4'b0011;
    wn(7);
    lit("k32_evt", bus.key_evt, m_evt, 4'b1100);
    wn(1);
    lit("blink_mode", {1'b0, bus.mode}, 4'(m_mode), 4'd3);
    wn(1);
    lit("blink_on", bus.led, m_led, 4'hF);
    wn(5);
    lit("blink_off", bus.led, m_led, 4'h0);
    wn(5);
    lit("blink_on2", bus.led, m_led, 4'hF);
    bus.key = 4'hF;
    wn(10);

    // SHIFT_R, then ALL_ON at phase 2, then back to SHIFT_R
    bus.key = 4'b1101;
    wn(12);
    bus.key = 4'b0111;
    wn(7);
    lit("shr_p2", bus.led, m_led, 4'b0010);
    lit("shr_mode", {1'b0, bus.mode}, 4'(m_mode), 4'd2);
    wn(1);
    lit("allon_mode", {1'b0, bus.mode}, 4'(m_mode), 4'd4);
    wn(1);
    lit("allon_led", bus.led, m_led, 4'hF);
    wn(10);
    lit("allon_hold", bus.led, m_led, 4'hF);
    bus.key = 4'hF;
    wn(10);
    bus.key = 4'b1101;
    wn(9);
    lit("shr_restart", bus.led, m_led, 4'b1000);
    lit("shr_mode2", {1'b0, bus.mode}, 4'(m_mode), 4'd2);
    wn(3);
    bus.key = 4'hF;
    wn(10);

    // reset pulse mid-BLINK with key2 held
    bus.key = 4'b1011;
    wn(12);
    lit("pre_rst_mode", {1'b0, bus.mode}, 4'(m_mode), 4'd3);
    #2 rst_n = 1'b0;
    #1;
    lit("arst_led", bus.led, m_led, 4'h0);
    lit("arst_mode", {1'b0, bus.mode}, 4'(m_mode), 4'd0);
    @(negedge sys_clk);
    #2 rst_n = 1'b1;
    wn(6);
    lit("post_rst_quiet", bus.key_evt, m_evt, 4'h0);
    wn(1);
    lit("post_rst_evt", bus.key_evt, m_evt, 4'b0100);
    wn(1);
    lit("post_rst_mode", {1'b0, bus.mode}, 4'(m_mode), 4'd3);
    wn(1);
    lit("post_rst_led", bus.led, m_led, 4'hF);
    bus.key = 4'hF;
    wn(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
